// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32 data-memory access controller.
// Holds FSM state encoding, funct3 access codes and fault codes.
// Imported by dmem_ctrl and dmem_lane_fmt.
package dmem_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Load codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  // Store codes (share encodings with the signed loads)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Completion status reported with o_done
  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FLT_ILLEGAL  = 2'b11;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: legality/alignment check, byte enables, store lane
// replication and load extraction/extension. Purely combinational, 0 cycles.
// No flow control; the caller decides when the results are used.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic                 we,
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [WORD_SIZE-1:0] wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 illegal,
  output logic                 misaligned,
  output logic [3:0]           be,
  output logic [WORD_SIZE-1:0] wdata_rep,
  output logic [WORD_SIZE-1:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte / half out of the full read word
  always_comb begin
    byte_sel = mem_rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
  end

  // Decode funct3 into legality, lane enables, store data and load result
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    be         = 4'b1111;
    wdata_rep  = wdata;
    rdata_ext  = mem_rdata;
    case (funct3)
      F3_LB: begin
        if (we) begin
          be        = 4'b0001 << addr_lo;
          wdata_rep = {4{wdata[7:0]}};
        end else begin
          rdata_ext = {{24{byte_sel[7]}}, byte_sel};
        end
      end
      F3_LH: begin
        misaligned = addr_lo[0];
        if (we) begin
          be        = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end else begin
          rdata_ext = {{16{half_sel[15]}}, half_sel};
        end
      end
      F3_LW: begin
        misaligned = (addr_lo != 2'b00);
      end
      F3_LBU: begin
        // Unsigned variants exist only for loads
        illegal   = we;
        rdata_ext = {24'h0, byte_sel};
      end
      F3_LHU: begin
        illegal    = we;
        misaligned = addr_lo[0];
        rdata_ext  = {16'h0, half_sel};
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Sequences one RV32 load/store onto a single-port variable-latency memory.
// Latency: request cycle N, memory access from N+1, o_done earliest at N+2.
// Stalls the pipeline while an access is outstanding; times out after TIMEOUT_CYC waits.
module dmem_ctrl #(
  parameter int WORD_SIZE   = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [WORD_SIZE-1:0]  i_addr,
  input  logic [WORD_SIZE-1:0]  i_wdata,
  output logic                  o_stall,
  output logic                  o_done,
  output logic [WORD_SIZE-1:0]  o_rdata,
  output logic [1:0]            o_fault,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [3:0]            o_mem_be,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic [WORD_SIZE-1:0]  o_mem_wdata,
  input  logic [WORD_SIZE-1:0]  i_mem_rdata,
  input  logic                  i_mem_ack
);
  import dmem_pkg::*;

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [1:0]            lo_q;
  logic [3:0]            be_q;
  logic [WORD_SIZE-1:0]  wdata_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [WORD_SIZE-1:0]  rdata_q;
  logic [1:0]            fault_q;

  logic                  in_wait;
  logic                  last;
  logic                  fmt_we;
  logic [2:0]            fmt_funct3;
  logic [1:0]            fmt_lo;
  logic                  illegal, misaligned;
  logic [3:0]            fmt_be;
  logic [WORD_SIZE-1:0]  fmt_wdata, fmt_rdata;
  logic                  addr_hi_unused;

  assign in_wait = (state == ST_WAIT);
  assign last    = (cnt == CNT_LAST);

  // Upper byte-address bits lie outside the memory window
  assign addr_hi_unused = ^i_addr[WORD_SIZE-1:MEM_ADDR_W+2];

  // The single formatter checks the live request in IDLE and formats the
  // read word from the latched request while waiting for the ack.
  assign fmt_we     = in_wait ? we_q     : i_we;
  assign fmt_funct3 = in_wait ? funct3_q : i_funct3;
  assign fmt_lo     = in_wait ? lo_q     : i_addr[1:0];

  dmem_lane_fmt u_fmt (
    .we         (fmt_we),
    .funct3     (fmt_funct3),
    .addr_lo    (fmt_lo),
    .wdata      (i_wdata),
    .mem_rdata  (i_mem_rdata),
    .illegal    (illegal),
    .misaligned (misaligned),
    .be         (fmt_be),
    .wdata_rep  (fmt_wdata),
    .rdata_ext  (fmt_rdata)
  );

  // Memory port is driven from registers and only while an access is live
  assign o_mem_en    = in_wait;
  assign o_mem_we    = in_wait & we_q;
  assign o_mem_be    = in_wait ? be_q    : 4'b0000;
  assign o_mem_addr  = in_wait ? addr_q  : '0;
  assign o_mem_wdata = in_wait ? wdata_q : '0;
  assign o_rdata     = rdata_q;
  assign o_fault     = fault_q;

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    o_stall   = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_req) begin
          o_stall   = 1'b1;
          state_nxt = (illegal || misaligned) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        o_stall = 1'b1;
        if (i_mem_ack || last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // Request still on i_req here is the one just completed
        o_done    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch the access in IDLE, count waits, capture the result on completion
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt      <= '0;
      addr_q   <= '0;
      lo_q     <= 2'b00;
      be_q     <= 4'b0000;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      rdata_q  <= '0;
      fault_q  <= FLT_OK;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (i_req) begin
            if (illegal) begin
              fault_q <= FLT_ILLEGAL;
              rdata_q <= '0;
            end else if (misaligned) begin
              fault_q <= FLT_MISALIGN;
              rdata_q <= '0;
            end else begin
              addr_q   <= i_addr[MEM_ADDR_W+1:2];
              lo_q     <= i_addr[1:0];
              be_q     <= fmt_be;
              wdata_q  <= fmt_wdata;
              we_q     <= i_we;
              funct3_q <= i_funct3;
            end
          end
        end
        ST_WAIT: begin
          if (i_mem_ack) begin
            // An ack in the final allowed cycle still completes normally
            fault_q <= FLT_OK;
            rdata_q <= we_q ? '0 : fmt_rdata;
            cnt     <= '0;
          end else if (last) begin
            fault_q <= FLT_TIMEOUT;
            rdata_q <= '0;
            cnt     <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed table-driven bench for dmem_ctrl plus reset-during-wait sequence.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst, req, we, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, done, mem_en, mem_we;
  logic [31:0] rdata, mem_wdata;
  logic [1:0]  fault;
  logic [3:0]  mem_be;
  logic [9:0]  mem_addr;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.WORD_SIZE(32), .MEM_ADDR_W(10), .TIMEOUT_CYC(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_funct3(funct3),
    .i_addr(addr), .i_wdata(wdata), .o_stall(stall), .o_done(done),
    .o_rdata(rdata), .o_fault(fault), .o_mem_en(mem_en), .o_mem_we(mem_we),
    .o_mem_be(mem_be), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .i_mem_ack(mem_ack)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          ack_at;   // WAIT cycle (1-based) carrying ack, 0 = never
    int          exp_en;
    int          exp_stall;
    logic [1:0]  exp_flt;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwd;
    logic [9:0]  exp_ma;
  } vec_t;

  localparam int NV = 17;
  vec_t vt[NV];

  // Observations from the last access
  int          n_stall, n_en;
  logic        got_done;
  logic [31:0] cap_rd, cap_mwd;
  logic [1:0]  cap_flt;
  logic [3:0]  cap_be;
  logic [9:0]  cap_ma;
  logic        cap_mwe;

  function automatic vec_t mk(input logic w, input logic [2:0] f, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] mr, input int ack,
                              input int en, input int st, input logic [1:0] fl,
                              input logic [31:0] rd, input logic [3:0] b,
                              input logic [31:0] mwd, input logic [9:0] ma);
    vec_t v;
    v.we = w; v.f3 = f; v.addr = a; v.wdata = wd; v.mrd = mr; v.ack_at = ack;
    v.exp_en = en; v.exp_stall = st; v.exp_flt = fl; v.exp_rd = rd;
    v.exp_be = b; v.exp_mwd = mwd; v.exp_ma = ma;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"},  32'(stall),    32'h0);
    chk({tag, "_done"},   32'(done),     32'h0);
    chk({tag, "_rdata"},  rdata,         32'h0);
    chk({tag, "_fault"},  32'(fault),    32'h0);
    chk({tag, "_mem_en"}, 32'(mem_en),   32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we),   32'h0);
    chk({tag, "_be"},     32'(mem_be),   32'h0);
    chk({tag, "_maddr"},  32'(mem_addr), 32'h0);
    chk({tag, "_mwdata"}, mem_wdata,     32'h0);
  endtask

  // Issue one request and follow it to o_done (bounded to 40 cycles)
  task automatic do_access(input vec_t v);
    n_stall = 0; n_en = 0; got_done = 1'b0;
    cap_rd = '0; cap_mwd = '0; cap_flt = '0; cap_be = '0; cap_ma = '0; cap_mwe = 1'b0;
    @(posedge clk); #1;
    req = 1'b1; we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata; mem_rdata = v.mrd;
    for (int c = 0; c < 40; c++) begin
      mem_ack = mem_en && ((n_en + 1) == v.ack_at);
      @(negedge clk);
      if (stall) n_stall++;
      if (mem_en) begin
        if (n_en == 0) begin
          cap_be = mem_be; cap_ma = mem_addr; cap_mwd = mem_wdata; cap_mwe = mem_we;
        end
        n_en++;
      end
      if (done) begin
        got_done = 1'b1; cap_rd = rdata; cap_flt = fault;
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (got_done) break;
    end
    req = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; funct3 = 3'b000; addr = '0; wdata = '0;
    mem_rdata = '0; mem_ack = 1'b0;

    //                we    f3      addr        wdata         mrd        ack en st flt    rd            be       mwd           ma
    vt[0]  = mk(1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 3,  3, 4, 2'b00, 32'hDEADBEEF, 4'b1111, 32'h0,        10'h40);
    vt[1]  = mk(1'b0, 3'b000, 32'h103, 32'h0,        32'h80123456, 1,  1, 2, 2'b00, 32'hFFFFFF80, 4'b1111, 32'h0,        10'h40);
    vt[2]  = mk(1'b0, 3'b100, 32'h103, 32'h0,        32'h80123456, 1,  1, 2, 2'b00, 32'h00000080, 4'b1111, 32'h0,        10'h40);
    vt[3]  = mk(1'b0, 3'b001, 32'h102, 32'h0,        32'h80123456, 1,  1, 2, 2'b00, 32'hFFFF8012, 4'b1111, 32'h0,        10'h40);
    vt[4]  = mk(1'b0, 3'b101, 32'h102, 32'h0,        32'h80123456, 1,  1, 2, 2'b00, 32'h00008012, 4'b1111, 32'h0,        10'h40);
    vt[5]  = mk(1'b0, 3'b000, 32'h101, 32'h0,        32'h80123456, 2,  2, 3, 2'b00, 32'h00000034, 4'b1111, 32'h0,        10'h40);
    vt[6]  = mk(1'b0, 3'b001, 32'h100, 32'h0,        32'h8012F456, 1,  1, 2, 2'b00, 32'hFFFFF456, 4'b1111, 32'h0,        10'h40);
    vt[7]  = mk(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 32'h55555555, 1,  1, 2, 2'b00, 32'h0,        4'b1100, 32'hABCDABCD, 10'h40);
    vt[8]  = mk(1'b1, 3'b000, 32'h105, 32'h000000A5, 32'h0,        1,  1, 2, 2'b00, 32'h0,        4'b0010, 32'hA5A5A5A5, 10'h41);
    vt[9]  = mk(1'b1, 3'b010, 32'h108, 32'hCAFEF00D, 32'h0,        1,  1, 2, 2'b00, 32'h0,        4'b1111, 32'hCAFEF00D, 10'h42);
    vt[10] = mk(1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1,  0, 1, 2'b01, 32'h0,        4'b0000, 32'h0,        10'h0);
    vt[11] = mk(1'b1, 3'b011, 32'h100, 32'h0,        32'h0,        1,  0, 1, 2'b11, 32'h0,        4'b0000, 32'h0,        10'h0);
    vt[12] = mk(1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        1,  0, 1, 2'b01, 32'h0,        4'b0000, 32'h0,        10'h0);
    vt[13] = mk(1'b1, 3'b100, 32'h100, 32'h0,        32'h0,        1,  0, 1, 2'b11, 32'h0,        4'b0000, 32'h0,        10'h0);
    vt[14] = mk(1'b0, 3'b010, 32'h010, 32'h0,        32'h0,        0, 16, 17, 2'b10, 32'h0,       4'b1111, 32'h0,        10'h4);
    vt[15] = mk(1'b0, 3'b010, 32'h010, 32'h0,        32'h12345678, 16, 16, 17, 2'b00, 32'h12345678, 4'b1111, 32'h0,     10'h4);
    vt[16] = mk(1'b0, 3'b111, 32'h100, 32'h0,        32'h0,        1,  0, 1, 2'b11, 32'h0,        4'b0000, 32'h0,        10'h0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");

    for (int i = 0; i < NV; i++) begin
      do_access(vt[i]);
      chk($sformatf("v%0d_done_seen", i), 32'(got_done), 32'h1);
      chk($sformatf("v%0d_en_cycles", i), 32'(n_en), 32'(vt[i].exp_en));
      chk($sformatf("v%0d_stall_cycles", i), 32'(n_stall), 32'(vt[i].exp_stall));
      chk($sformatf("v%0d_fault", i), 32'(cap_flt), 32'(vt[i].exp_flt));
      if (vt[i].exp_flt == 2'b00)
        chk($sformatf("v%0d_rdata", i), cap_rd, vt[i].exp_rd);
      if (vt[i].exp_en > 0) begin
        chk($sformatf("v%0d_be", i), 32'(cap_be), 32'(vt[i].exp_be));
        chk($sformatf("v%0d_maddr", i), 32'(cap_ma), 32'(vt[i].exp_ma));
        chk($sformatf("v%0d_mwe", i), 32'(cap_mwe), 32'(vt[i].we));
        if (vt[i].we)
          chk($sformatf("v%0d_mwdata", i), cap_mwd, vt[i].exp_mwd);
      end
      // Cycle after completion: pulse gone, result held
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'h0);
      chk($sformatf("v%0d_fault_hold", i), 32'(fault), 32'(vt[i].exp_flt));
    end

    // Reset asserted during the second WAIT cycle abandons the access
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h200; mem_rdata = 32'h0BADF00D;
    @(posedge clk); #1;                   // WAIT 1
    @(posedge clk); #1;                   // WAIT 2
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_en", 32'(mem_en), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    chk_zero("rst_wait");
    mem_ack = 1'b1;                       // late ack while IDLE
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_done",  32'(done),   32'h0);
    chk("late_ack_en",    32'(mem_en), 32'h0);
    chk("late_ack_stall", 32'(stall),  32'h0);

    do_access(mk(1'b0, 3'b010, 32'h204, 32'h0, 32'h13579BDF, 1, 1, 2, 2'b00,
                 32'h13579BDF, 4'b1111, 32'h0, 10'h81));
    chk("post_rst_done",  32'(got_done), 32'h1);
    chk("post_rst_fault", 32'(cap_flt),  32'h0);
    chk("post_rst_rdata", cap_rd,        32'h13579BDF);
    chk("post_rst_maddr", 32'(cap_ma),   32'h81);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
